// File: rtl/bcd_time_counter_if.sv
// bcd_time_counter_if: control, time-set and display/tick signals of the time-of-day counter
interface bcd_time_counter_if;
  logic       run;
  logic       mode_12h;
  logic       load;
  logic [7:0] load_hours;
  logic [7:0] load_minutes;
  logic [7:0] load_seconds;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [7:0] hours;
  logic       pm;
  logic       toggle;
  logic       sec_tick;
  logic       min_tick;
  logic       hour_tick;
  logic       day_tick;
  logic       load_err;
  modport master (
    output run, mode_12h, load, load_hours, load_minutes, load_seconds,
    input  seconds, minutes, hours, pm, toggle, sec_tick, min_tick, hour_tick, day_tick, load_err
  );
  modport slave (
    input  run, mode_12h, load, load_hours, load_minutes, load_seconds,
    output seconds, minutes, hours, pm, toggle, sec_tick, min_tick, hour_tick, day_tick, load_err
  );
endinterface

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: prescaled BCD time-of-day counter with 12/24h decode, validated load and rollover ticks
module bcd_time_counter #(
  parameter int TICKS_PER_SEC = 1000
) (
  input logic clk,
  input logic reset,
  bcd_time_counter_if.slave bus
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  logic [PW-1:0] r_p, w_p_next;
  logic [7:0] r_sec, r_min, r_hr;
  logic r_toggle, r_sec_tick, r_min_tick, r_hour_tick, r_day_tick, r_load_err;
  logic w_wrap, w_valid, w_load_ok, w_adv, w_sec_c, w_min_c, w_day_c;
  logic [4:0] w_hbin, w_h12, w_h12_lo;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v <= max;
  endfunction
  always_comb begin
    w_valid   = bcd_ok(bus.load_seconds, 8'h59) && bcd_ok(bus.load_minutes, 8'h59) && bcd_ok(bus.load_hours, 8'h23);
    w_load_ok = bus.load && w_valid;
    w_wrap    = bus.run && r_p == PW'(TICKS_PER_SEC - 1);
    w_adv     = w_wrap && !w_load_ok;
    w_p_next  = w_load_ok ? '0 : !bus.run ? r_p : w_wrap ? '0 : r_p + PW'(1);
    w_sec_c   = r_sec == 8'h59;
    w_min_c   = w_sec_c && r_min == 8'h59;
    w_day_c   = w_min_c && r_hr == 8'h23;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p         <= '0;
      r_sec       <= '0;
      r_min       <= '0;
      r_hr        <= '0;
      r_toggle    <= 1'b0;
      r_sec_tick  <= 1'b0;
      r_min_tick  <= 1'b0;
      r_hour_tick <= 1'b0;
      r_day_tick  <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_p         <= w_p_next;
      r_toggle    <= w_p_next >= PW'(TICKS_PER_SEC / 2);
      r_sec_tick  <= w_adv;
      r_min_tick  <= w_adv && w_sec_c;
      r_hour_tick <= w_adv && w_min_c;
      r_day_tick  <= w_adv && w_day_c;
      if (bus.load) r_load_err <= !w_valid;
      if (w_load_ok) begin
        r_sec <= bus.load_seconds;
        r_min <= bus.load_minutes;
        r_hr  <= bus.load_hours;
      end else if (w_adv) begin
        r_sec <= w_sec_c ? 8'h00 : bcd_inc(r_sec);
        if (w_sec_c) r_min <= w_min_c ? 8'h00 : bcd_inc(r_min);
        if (w_min_c) r_hr <= w_day_c ? 8'h00 : bcd_inc(r_hr);
      end
    end
  end
  // 12-hour decode goes through binary so h-12 needs no BCD borrow logic
  always_comb begin
    w_hbin   = 5'(r_hr[7:4]) * 5'd10 + 5'(r_hr[3:0]);
    w_h12    = w_hbin == 5'd0 ? 5'd12 : w_hbin > 5'd12 ? w_hbin - 5'd12 : w_hbin;
    w_h12_lo = w_h12 >= 5'd10 ? w_h12 - 5'd10 : w_h12;
  end
  assign bus.hours     = bus.mode_12h ? {3'b000, w_h12 >= 5'd10, w_h12_lo[3:0]} : r_hr;
  assign bus.pm        = w_hbin >= 5'd12;
  assign bus.seconds   = r_sec;
  assign bus.minutes   = r_min;
  assign bus.toggle    = r_toggle;
  assign bus.sec_tick  = r_sec_tick;
  assign bus.min_tick  = r_min_tick;
  assign bus.hour_tick = r_hour_tick;
  assign bus.day_tick  = r_day_tick;
  assign bus.load_err  = r_load_err;
endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
Parametrised time-of-day counter for the digital clock datapath, the successor to the three-clock seconds/minutes/hours counter. It runs from one system clock with an internal prescaler instead of separate seconds/minutes/hours clocks. It produces BCD seconds, minutes and hours, a 12/24-hour display mode, a validated time-set load port, per-unit rollover pulses, and a half-second blink toggle for the display.

Parameters:
TICKS_PER_SEC, 1000, clk cycles per second; must be even and >= 2.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
run  in  1  count enable; 0 freezes prescaler, time and toggle.
mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display.
load  in  1  time-set strobe, sampled each edge.
load_hours  in  8  BCD, 24-hour format, 0x00-0x23.
load_minutes  in  8  BCD, 0x00-0x59.
load_seconds  in  8  BCD, 0x00-0x59.
seconds  out  8  BCD seconds, registered.
minutes  out  8  BCD minutes, registered.
hours  out  8  BCD display hours, decoded from the internal 24-hour register.
pm  out  1  1 when internal hour >= 12, in either mode.
toggle  out  1  blink: 0 in the first half of each second, 1 in the second half.
sec_tick  out  1  one-cycle pulse on each seconds update.
min_tick  out  1  one-cycle pulse on a minutes update.
hour_tick  out  1  one-cycle pulse on an hours update.
day_tick  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap.
load_err  out  1  sticky flag: last load was rejected.

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - Prescaler, time registers, toggle, all ticks and load_err go to 0.
  - hours reads 0x00 in 24-hour mode and 0x12 in 12-hour mode; pm=0.
- Prescaler p counts 0..TICKS_PER_SEC-1 while run=1.
  - At p=TICKS_PER_SEC-1 with run=1, p wraps to 0 and the time advances one second on the same edge.
  - The new time is visible the cycle after the wrap; sec_tick is high in that same cycle only.
- toggle is registered and equals (p >= TICKS_PER_SEC/2) after each edge.
- BCD increment: the units nibble goes 9->0 with a carry into tens.
  - seconds 0x59 -> 0x00 carries to minutes; min_tick is high with sec_tick.
  - minutes 0x59 -> 0x00 carries to hours; hour_tick is high.
  - hours 0x23 -> 0x00 asserts day_tick.
  - At 23:59:59 -> 00:00:00 all four ticks are high in the same single cycle.
- run=0: p, time and toggle hold. Ticks are 0. Resuming continues from the held p, so no partial second is lost or repeated.
- Load (load=1 at an edge) is honoured regardless of run.
  - Validation: every nibble <= 9, seconds <= 0x59, minutes <= 0x59, hours <= 0x23.
  - Valid load: all three time registers load, p=0, toggle=0, load_err=0. No tick pulses are generated.
  - Invalid load: time is unchanged, p continues normally, load_err=1.
  - load_err holds until the next valid load or reset.
  - Load coincident with a prescaler wrap: the load wins, the second advance is dropped, and no ticks fire.
  - load held high for several cycles reloads every cycle, keeping p at 0.
- Hours decode (combinational from the internal hour h and mode_12h):
  - 24-hour mode: hours = h.
  - 12-hour mode: h=0 -> 0x12; h=1..11 -> h; h=12 -> 0x12; h=13..23 -> h-12, in BCD.
  - pm = (h >= 12) in both modes.
  - A mode_12h change alters only the decode, never the state.
- Internal BCD values never leave their legal ranges. There are no unused or illegal states reachable after reset.

Test Plan:
- TICKS_PER_SEC=4, reset then run=1 -> toggle per cycle 0,0,1,1,0; after 4 edges seconds=0x01 with sec_tick high for exactly 1 cycle; min_tick=0.
- Load 0x23/0x59/0x58, run for 8 edges -> 23:59:59 then 00:00:00; sec/min/hour/day_tick all high in one cycle; load_err=0.
- Load hours=0x24, then seconds=0x5A, then minutes=0x0A -> each rejected, time unchanged, load_err=1; then a valid load of 0x10/0x20/0x30 -> time 10:20:30, load_err=0.
- mode_12h=1: h=0x00 -> hours 0x12, pm=0; 0x11 -> 0x11, pm=0; 0x12 -> 0x12, pm=1; 0x13 -> 0x01, pm=1; 0x23 -> 0x11, pm=1.
- At p=2 drop run for 10 cycles -> seconds, p and toggle frozen, no ticks; after run=1, sec_tick follows after exactly 2 more edges.
- Load asserted on the wrap edge -> loaded value shown, no sec_tick. Separately, reset pulled low between edges at 05:06:07 -> all outputs zero before the next clk edge.
